// File: rtl/ann_out_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : ann_out_pingpong_buf
// Brief    : Double-buffered ANN layer-output store with commit/release bank
//            swapping; optional per-bank argmax under ANN_OUT_ARGMAX_EN.
// Revision : 1.0  initial release
// ============================================================================
module ann_out_pingpong_buf #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 50,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              wr_err,
    output logic [ADDR_W-1:0] rd_max_idx,
    output logic [DATA_W-1:0] rd_max_val
);

    localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [2][DEPTH];

    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [1:0]  r_full_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic        r_rd_data_vld;
    logic        r_wr_err;

    logic        w_wr_ok;
    logic        w_commit;
    logic        w_release;
    logic        w_rd_ok;
    logic        w_rd_in_range;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;

    assign wr_ready      = (r_full_cnt != 2'd2);
    assign rd_valid      = (r_full_cnt != 2'd0);
    assign w_wr_ok       = wr_en & wr_ready & ({1'b0, wr_addr} < c_depth);
    assign w_commit      = w_wr_ok & wr_last;
    assign w_release     = rd_release & rd_valid;
    assign w_rd_ok       = rd_en & rd_valid;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
    // Clamp indices so out-of-range addresses never reach the array
    assign w_wr_idx      = ({1'b0, wr_addr} < c_depth) ? wr_addr : '0;
    assign w_rd_idx      = w_rd_in_range ? rd_addr : '0;

    assign rd_data       = r_rd_data;
    assign rd_data_vld   = r_rd_data_vld;
    assign wr_err        = r_wr_err;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_bank][w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_full_cnt    <= 2'd0;
            r_rd_data     <= '0;
            r_rd_data_vld <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_err      <= wr_en & ~w_wr_ok;
            r_rd_data_vld <= w_rd_ok;
            // Read samples the pre-release bank when release coincides
            if (w_rd_ok) begin
                r_rd_data <= w_rd_in_range ? r_mem[r_rd_bank][w_rd_idx] : '0;
            end
            if (w_commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_commit && !w_release) begin
                r_full_cnt <= r_full_cnt + 2'd1;
            end else if (!w_commit && w_release) begin
                r_full_cnt <= r_full_cnt - 2'd1;
            end
        end
    end

`ifdef ANN_OUT_ARGMAX_EN
    logic [DATA_W-1:0] r_run_val;
    logic [ADDR_W-1:0] r_run_idx;
    logic              r_run_seeded;
    logic [DATA_W-1:0] r_bank_val [2];
    logic [ADDR_W-1:0] r_bank_idx [2];
    logic              w_upd;
    logic [DATA_W-1:0] w_nxt_val;
    logic [ADDR_W-1:0] w_nxt_idx;

    // Strict compare keeps the earliest-written index on ties
    assign w_upd     = w_wr_ok & (~r_run_seeded | ($signed(wr_data) > $signed(r_run_val)));
    assign w_nxt_val = w_upd ? wr_data : r_run_val;
    assign w_nxt_idx = w_upd ? wr_addr : r_run_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_val     <= '0;
            r_run_idx     <= '0;
            r_run_seeded  <= 1'b0;
            r_bank_val[0] <= '0;
            r_bank_val[1] <= '0;
            r_bank_idx[0] <= '0;
            r_bank_idx[1] <= '0;
        end else if (w_wr_ok) begin
            r_run_val    <= w_nxt_val;
            r_run_idx    <= w_nxt_idx;
            r_run_seeded <= ~wr_last;
            if (wr_last) begin
                r_bank_val[r_wr_bank] <= w_nxt_val;
                r_bank_idx[r_wr_bank] <= w_nxt_idx;
            end
        end
    end

    assign rd_max_val = rd_valid ? r_bank_val[r_rd_bank] : '0;
    assign rd_max_idx = rd_valid ? r_bank_idx[r_rd_bank] : '0;
`else
    assign rd_max_val = '0;
    assign rd_max_idx = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ann_out_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ann_out_pingpong_buf
// Brief    : Directed, table-driven self-checking bench for the ping-pong buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_ann_out_pingpong_buf;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 50;
    localparam int ADDR_W = 6;
`ifdef ANN_OUT_ARGMAX_EN
    localparam bit ARG = 1'b1;
`else
    localparam bit ARG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_release;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;
    logic              wr_err;
    logic [ADDR_W-1:0] rd_max_idx;
    logic [DATA_W-1:0] rd_max_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ann_out_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .wr_err(wr_err), .rd_max_idx(rd_max_idx), .rd_max_val(rd_max_val)
    );

    typedef struct {
        logic        wr_en;
        int          wr_addr;
        int          wr_data;
        logic        wr_last;
        logic        rd_en;
        int          rd_addr;
        logic        rd_release;
        logic        e_ready;
        logic        e_valid;
        logic        e_vld;
        int          e_data;
        logic        e_err;
    } vec_t;

    vec_t tab_a[10];
    vec_t tab_b[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d, input logic last);
        idle();
        wr_en = 1'b1; wr_addr = a[ADDR_W-1:0]; wr_data = d[DATA_W-1:0]; wr_last = last;
        step();
        idle();
    endtask

    task automatic rd(input int a);
        idle();
        rd_en = 1'b1; rd_addr = a[ADDR_W-1:0];
        step();
        idle();
    endtask

    task automatic apply(input vec_t v, input string tag);
        wr_en = v.wr_en; wr_addr = v.wr_addr[ADDR_W-1:0]; wr_data = v.wr_data[DATA_W-1:0];
        wr_last = v.wr_last; rd_en = v.rd_en; rd_addr = v.rd_addr[ADDR_W-1:0];
        rd_release = v.rd_release;
        step();
        idle();
        chk({tag, "_ready"}, 32'(wr_ready), 32'(v.e_ready));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(v.e_valid));
        chk({tag, "_vld"},   32'(rd_data_vld), 32'(v.e_vld));
        chk({tag, "_data"},  32'(rd_data), 32'(v.e_data));
        chk({tag, "_err"},   32'(wr_err), 32'(v.e_err));
    endtask

    function automatic int pat(input int a);
        case (a)
            0: return 3;
            1: return 9'h1FE;
            2: return 9;
            3: return 9;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    initial begin
        // wr_en wa wd last rd_en ra rel | ready valid vld data err
        tab_a[0] = '{1, 49, 149, 1, 1,  7, 0, 0, 1, 1,   7, 0};
        tab_a[1] = '{1,  3, 511, 0, 0,  0, 0, 0, 1, 0,   7, 1};
        tab_a[2] = '{0,  0,   0, 0, 0,  0, 0, 0, 1, 0,   7, 0};
        tab_a[3] = '{0,  0,   0, 0, 1,  3, 0, 0, 1, 1,   3, 0};
        tab_a[4] = '{0,  0,   0, 0, 1, 49, 1, 1, 1, 1,  49, 0};
        tab_a[5] = '{0,  0,   0, 0, 1,  3, 0, 1, 1, 1, 103, 0};
        tab_a[6] = '{0,  0,   0, 0, 1, 55, 0, 1, 1, 1,   0, 0};
        tab_a[7] = '{1, 60,   5, 0, 0,  0, 0, 1, 1, 0,   0, 1};
        tab_a[8] = '{1, 50,   5, 1, 0,  0, 0, 1, 1, 0,   0, 1};
        tab_a[9] = '{1,  0, 200, 0, 0,  0, 0, 1, 1, 0,   0, 0};
        tab_b[0] = '{1, 49, 249, 1, 0,  0, 1, 1, 1, 0,   0, 0};
        tab_b[1] = '{0,  0,   0, 0, 1, 10, 0, 1, 1, 1, 210, 0};
        tab_b[2] = '{0,  0,   0, 0, 1,  0, 0, 1, 1, 1, 200, 0};

        idle();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data",  32'(rd_data), 0);
        chk("rst_vld",   32'(rd_data_vld), 0);
        chk("rst_err",   32'(wr_err), 0);
        chk("rst_maxi",  32'(rd_max_idx), 0);
        chk("rst_maxv",  32'(rd_max_val), 0);

        // Frame 0 into bank0
        for (int a = 0; a < DEPTH; a++) wr(a, a, a == DEPTH - 1);
        chk("f0_valid", 32'(rd_valid), 1);
        chk("f0_ready", 32'(wr_ready), 1);
        chk("f0_err",   32'(wr_err), 0);
        chk("f0_maxi",  32'(rd_max_idx), ARG ? 49 : 0);
        chk("f0_maxv",  32'(rd_max_val), ARG ? 49 : 0);
        rd(7);
        chk("f0_rd7",   32'(rd_data), 7);
        chk("f0_vld7",  32'(rd_data_vld), 1);
        step();
        chk("f0_vld_drop", 32'(rd_data_vld), 0);

        // Frame 1 into bank1, last word and overflow cases from the table
        for (int a = 0; a < DEPTH - 1; a++) wr(a, 100 + a, 1'b0);
        for (int i = 0; i < 10; i++) apply(tab_a[i], $sformatf("A%0d", i));
        for (int a = 1; a < DEPTH - 1; a++) wr(a, 200 + a, 1'b0);
        apply(tab_b[0], "B0");
        chk("B0_maxi", 32'(rd_max_idx), ARG ? 49 : 0);
        chk("B0_maxv", 32'(rd_max_val), ARG ? 249 : 0);
        apply(tab_b[1], "B1");
        apply(tab_b[2], "B2");

        // Partial frame into bank1, then reset mid-frame
        for (int a = 0; a < 20; a++) wr(a, 77, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_ready", 32'(wr_ready), 1);
        chk("mid_valid", 32'(rd_valid), 0);
        chk("mid_data",  32'(rd_data), 0);
        chk("mid_maxv",  32'(rd_max_val), 0);
        rd(2);
        chk("norv_vld",  32'(rd_data_vld), 0);
        chk("norv_data", 32'(rd_data), 0);
        idle(); rd_release = 1'b1; wr_last = 1'b1;
        step();
        idle();
        chk("ign_valid", 32'(rd_valid), 0);
        chk("ign_err",   32'(wr_err), 0);

        for (int a = 0; a < DEPTH; a++) wr(a, pat(a), a == DEPTH - 1);
        chk("p_valid", 32'(rd_valid), 1);
        chk("p_maxi",  32'(rd_max_idx), ARG ? 2 : 0);
        chk("p_maxv",  32'(rd_max_val), ARG ? 9 : 0);
        rd(1);
        chk("p_rd1",   32'(rd_data), 32'h1FE);
        rd(2);
        chk("p_rd2",   32'(rd_data), 9);
        rd(20);
        chk("p_rd20",  32'(rd_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
